latch_dump_serializer: RTL and testbench
========================================

LATCH_DUMP_SERIALIZER -- requirements
Module: latch_dump_serializer

Interface
REQ-001 Parameter NB_DATA, default 44, is the width of the pipeline-latch debug vector to dump (IF/ID snapshot size with NB_PC=6).
REQ-002 Parameter NB_BYTE, default 8, is the width of one transmitted byte.
REQ-003 Parameter HEADER, default 8'hA5, is the frame header byte.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 i_clk  input  1  rising-edge clock.
REQ-006 i_reset  input  1  asynchronous reset, active-low (0 = reset).
REQ-007 i_start  input  1  request to snapshot i_latch_data and send one frame.
REQ-008 i_latch_data  input  NB_DATA  latch debug vector; bit 0 is flush, bit 1 is write-enable, bit 43 is EOF.
REQ-009 i_tx_done  input  1  one-cycle tick from the UART transmitter; the current byte is finished.
REQ-010 o_tx_start  output  1  one-cycle pulse that launches a UART byte.
REQ-011 o_tx_data  output  NB_BYTE  byte to transmit; held stable from the o_tx_start cycle until i_tx_done.
REQ-012 o_busy  output  1  high while a frame is in progress.
REQ-013 o_done  output  1  one-cycle pulse after the last byte completes.
REQ-014 o_eof_seen  output  1  EOF bit (MSB) of the last captured snapshot.

Function
REQ-015 The frame SHALL be the HEADER byte followed by N_BYTES = ceil(NB_DATA/NB_BYTE) data bytes: 6 bytes at the defaults, 7 bytes in total.
REQ-016 Data bytes SHALL be sent LSB-first: byte k = snapshot[8k+7:8k], with the last byte zero-padded above NB_DATA-1 (byte 5 = {4'b0, snap[43:40]}).
REQ-017 The FSM SHALL have the states IDLE, SEND, WAIT, DONE.
REQ-018 IDLE: on i_start=1, the block SHALL register the snapshot, set byte_idx=0, update o_eof_seen=snap[NB_DATA-1], and go to SEND.
REQ-019 SEND: the block SHALL assert o_tx_start for exactly one cycle with o_tx_data = (byte_idx==0 ? HEADER : data byte byte_idx-1), then go to WAIT.
REQ-020 WAIT: on i_tx_done, if byte_idx==N_BYTES the block SHALL go to DONE; otherwise it SHALL increment byte_idx and go to SEND.
REQ-021 DONE: the block SHALL assert o_done for one cycle, then return to IDLE.
REQ-022 Latency: o_tx_start for the header SHALL rise 1 cycle after i_start is sampled; each following o_tx_start SHALL rise 1 cycle after the i_tx_done that closes the previous byte.
REQ-023 o_busy SHALL be 1 in SEND, WAIT and DONE, and 0 in IDLE.
REQ-024 i_start SHALL be ignored outside IDLE; no queuing, and the snapshot is not overwritten mid-frame.
REQ-025 i_tx_done SHALL be ignored outside WAIT, including a tick coincident with SEND.
REQ-026 i_start held high SHALL start a new frame on the first IDLE cycle after DONE.
REQ-027 byte_idx SHALL be ceil(log2(N_BYTES+1)) bits wide and SHALL never exceed N_BYTES.
REQ-028 The snapshot register SHALL be NB_DATA bits; padding SHALL be applied only at output muxing.

Reset
REQ-029 While i_reset=0, asynchronously: state=IDLE, byte_idx=0, snapshot=0, o_tx_start=0, o_tx_data=0, o_busy=0, o_done=0, o_eof_seen=0.
REQ-030 A reset mid-frame SHALL abort the frame with no o_done, and SHALL require a fresh i_start after release.
REQ-031 The first rising edge after reset release SHALL be able to accept i_start.

Verification
REQ-032 i_latch_data=44'h8AB_CDEF_0123, i_start pulse, i_tx_done 10 cycles after each o_tx_start -> o_tx_data sequence A5,23,01,EF,CD,AB,08; 7 o_tx_start pulses; o_done once; o_eof_seen=1.
REQ-033 i_latch_data changes and i_start pulses during WAIT of byte 2 -> frame bytes unchanged; no second frame follows.
REQ-034 i_tx_done pulses in IDLE and in the SEND cycle -> no o_tx_start advance; byte_idx unchanged.
REQ-035 i_reset=0 for one cycle during WAIT of byte 3 -> all outputs 0 immediately; no o_done; a new i_start yields a full 7-byte frame starting with A5.
REQ-036 i_start held high across two frames -> back-to-back frames, with o_done then the header o_tx_start 2 cycles apart; o_busy low for exactly one cycle between them.
REQ-037 Snapshot with bit 43=0 (44'h0000_0000_0003) -> bytes A5,03,00,00,00,00,00; o_eof_seen=0.

Source files
------------

// File: rtl/latch_dump_serializer.sv
// Pipeline-latch debug dump: snapshots a latch vector on request and streams
// it to a UART transmitter as a header byte followed by LSB-first data bytes.
module latch_dump_serializer #(
    parameter int unsigned         NB_DATA = 44,
    parameter int unsigned         NB_BYTE = 8,
    parameter logic [NB_BYTE-1:0]  HEADER  = 8'hA5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_latch_data,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_eof_seen
);

    localparam int unsigned N_BYTES = (NB_DATA + NB_BYTE - 1) / NB_BYTE;
    localparam int unsigned NB_IDX  = $clog2(N_BYTES + 1);
    localparam int unsigned NB_PAD  = N_BYTES * NB_BYTE;
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state;
    logic [NB_IDX-1:0]    byte_idx;
    logic [NB_DATA-1:0]   snapshot;

    // Frame byte for a given index: 0 is the header, k>0 is data byte k-1,
    // zero-padded above the snapshot MSB.
    function automatic logic [NB_BYTE-1:0] frame_byte(
        input logic [NB_IDX-1:0]  idx,
        input logic [NB_DATA-1:0] snap
    );
        logic [NB_PAD-1:0] padded;
        padded = NB_PAD'(snap);
        if (idx == '0) begin
            frame_byte = HEADER;
        end else begin
            frame_byte = NB_BYTE'(padded >> (NB_BYTE * (32'(idx) - 32'd1)));
        end
    endfunction

    // Frame sequencer; outputs are registered for the state being entered so
    // o_tx_start/o_busy/o_done line up with SEND/busy states/DONE.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            byte_idx   <= '0;
            snapshot   <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_eof_seen <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        snapshot   <= i_latch_data;
                        byte_idx   <= '0;
                        o_eof_seen <= i_latch_data[NB_DATA-1];
                        o_tx_start <= 1'b1;
                        o_tx_data  <= HEADER;
                        o_busy     <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    // Launch cycle; a coincident tx_done belongs to no byte.
                    state <= WAIT;
                end
                WAIT: begin
                    if (i_tx_done) begin
                        if (byte_idx == LAST_IDX) begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            byte_idx   <= byte_idx + 1'b1;
                            o_tx_start <= 1'b1;
                            o_tx_data  <= frame_byte(byte_idx + 1'b1, snapshot);
                            state      <= SEND;
                        end
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_dump_serializer.sv
// Self-checking bench for latch_dump_serializer: a byte-queue reference model,
// an auto-responding UART stub, directed scenarios and randomized frames.
module tb_latch_dump_serializer;

    localparam int unsigned NB_DATA = 44;
    localparam int unsigned NB_BYTE = 8;
    localparam logic [7:0]  HDR     = 8'hA5;

    logic               i_clk;
    logic               i_reset;
    logic               i_start;
    logic [NB_DATA-1:0] i_latch_data;
    logic               i_tx_done;
    logic               o_tx_start;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_busy;
    logic               o_done;
    logic               o_eof_seen;

    latch_dump_serializer #(.NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .HEADER(HDR)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_latch_data (i_latch_data),
        .i_tx_done    (i_tx_done),
        .o_tx_start   (o_tx_start),
        .o_tx_data    (o_tx_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_eof_seen   (o_eof_seen)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: a frame is a queue of bytes; one byte goes out per
    // launch, the next launches on the cycle after a tick that is not in the
    // launch cycle itself, and o_done follows the tick that closes the last byte.
    logic       m_start    = 1'b0;
    logic       m_done     = 1'b0;
    logic       m_busy     = 1'b0;
    logic       m_eof      = 1'b0;
    logic [7:0] m_data     = 8'h00;
    logic       m_inflight = 1'b0;
    logic [7:0] m_q[$];

    always @(posedge i_clk or negedge i_reset) begin
        logic was_start;
        logic was_done;
        if (!i_reset) begin
            m_start = 1'b0; m_done = 1'b0; m_busy = 1'b0; m_eof = 1'b0;
            m_data = 8'h00; m_inflight = 1'b0;
            m_q.delete();
        end else begin
            was_start = m_start;
            was_done  = m_done;
            m_start   = 1'b0;
            m_done    = 1'b0;
            if (!m_busy) begin
                if (i_start) begin
                    m_q.delete();
                    for (int k = 0; k < 6; k++) m_q.push_back(8'(i_latch_data >> (8 * k)));
                    m_data = HDR; m_start = 1'b1; m_busy = 1'b1;
                    m_eof = i_latch_data[NB_DATA-1]; m_inflight = 1'b1;
                end
            end else if (was_done) begin
                m_busy = 1'b0;
            end else if (m_inflight && !was_start && i_tx_done) begin
                if (m_q.size() == 0) begin
                    m_inflight = 1'b0;
                    m_done     = 1'b1;
                end else begin
                    m_data  = m_q.pop_front();
                    m_start = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare against the model, plus a log of launched bytes.
    int         cyc = 0;
    int         n_starts = 0;
    int         n_dones = 0;
    int         last_done_cyc = 0;
    int         idle_run = 0;
    int         last_idle_run = 0;
    logic [7:0] log_mem   [0:1023];
    int         start_cyc [0:1023];

    always @(negedge i_clk) begin
        cyc++;
        check("tx_start", 64'(o_tx_start), 64'(m_start));
        check("tx_data",  64'(o_tx_data),  64'(m_data));
        check("busy",     64'(o_busy),     64'(m_busy));
        check("done",     64'(o_done),     64'(m_done));
        check("eof_seen", 64'(o_eof_seen), 64'(m_eof));
        if (o_tx_start === 1'b1 && n_starts < 1024) begin
            log_mem[n_starts]   = o_tx_data;
            start_cyc[n_starts] = cyc;
            n_starts++;
        end
        if (o_done === 1'b1) begin
            last_done_cyc = cyc;
            n_dones++;
        end
        if (o_busy !== 1'b1) idle_run++;
        else begin
            if (idle_run > 0) last_idle_run = idle_run;
            idle_run = 0;
        end
    end

    // UART stub: ticks i_tx_done resp_delay cycles after each launch; inject
    // forces an extra tick in the current cycle.
    int   resp_delay = 10;
    logic inject     = 1'b0;

    initial begin
        int   cnt;
        logic armed;
        cnt = 0; armed = 1'b0; i_tx_done = 1'b0;
        forever begin
            @(posedge i_clk);
            #2;
            i_tx_done = 1'b0;
            if (!i_reset) begin
                armed = 1'b0;
            end else begin
                if (inject) i_tx_done = 1'b1;
                else if (armed) begin
                    cnt--;
                    if (cnt == 0) begin
                        i_tx_done = 1'b1;
                        armed = 1'b0;
                    end
                end
                if (o_tx_start === 1'b1) begin
                    cnt = resp_delay;
                    armed = 1'b1;
                end
            end
        end
    end

    logic [7:0] exp_032 [7] = '{8'hA5, 8'h23, 8'h01, 8'hEF, 8'hCD, 8'hAB, 8'h08};
    logic [7:0] exp_033 [7] = '{8'hA5, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    logic [7:0] exp_034 [7] = '{8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08};
    logic [7:0] exp_037 [7] = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    logic noise = 1'b0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic wait_done(input string name, input int max);
        int k;
        k = 0;
        while (o_done !== 1'b1 && k < max) begin
            step(1);
            k++;
            if (noise) i_latch_data = 44'({$urandom, $urandom});
        end
        check({name, "_done_seen"}, 64'(o_done), 64'd1);
    endtask

    task automatic wait_starts(input string name, input int target, input int max);
        int k;
        k = 0;
        while (n_starts < target && k < max) begin
            step(1);
            k++;
        end
        check({name, "_starts_reached"}, 64'(n_starts >= target), 64'd1);
    endtask

    task automatic cmp_frame(input string name, input int base, input logic [7:0] exp [7]);
        for (int k = 0; k < 7; k++)
            check($sformatf("%s_byte%0d", name, k), 64'(log_mem[base + k]), 64'(exp[k]));
    endtask

    task automatic pulse_start(input logic [NB_DATA-1:0] data);
        i_latch_data = data;
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
    endtask

    initial begin
        int base;
        int d0;
        int d1;
        i_reset = 1'b0; i_start = 1'b0; i_latch_data = '0;

        // Reset state
        step(3);
        check("rst_tx_start", 64'(o_tx_start), 64'd0);
        check("rst_tx_data",  64'(o_tx_data),  64'd0);
        check("rst_busy",     64'(o_busy),     64'd0);
        check("rst_done",     64'(o_done),     64'd0);
        check("rst_eof",      64'(o_eof_seen), 64'd0);

        // Start accepted on the first edge after release; reference frame
        base = n_starts; d0 = n_dones;
        i_reset = 1'b1;
        pulse_start(44'h8AB_CDEF_0123);
        check("f032_hdr_latency", 64'(o_tx_start), 64'd1);
        wait_done("f032", 300);
        step(2);
        cmp_frame("f032", base, exp_032);
        check("f032_starts", 64'(n_starts - base), 64'd7);
        check("f032_dones",  64'(n_dones - d0),    64'd1);
        check("f032_eof",    64'(o_eof_seen),      64'd1);
        check("f032_gap",    64'(start_cyc[base + 1] - start_cyc[base]), 64'd11);

        // Start requests and data changes mid-frame are ignored
        base = n_starts; d0 = n_dones;
        pulse_start(44'h123_4567_89AB);
        wait_starts("f033", base + 3, 200);
        step(2);
        pulse_start(44'hFFF_FFFF_FFFF);
        step(3);
        pulse_start(44'h555_5555_5555);
        wait_done("f033", 300);
        step(40);
        cmp_frame("f033", base, exp_033);
        check("f033_starts", 64'(n_starts - base), 64'd7);
        check("f033_dones",  64'(n_dones - d0),    64'd1);
        check("f033_eof",    64'(o_eof_seen),      64'd0);

        // Stray ticks in IDLE and in the launch cycle
        base = n_starts;
        inject = 1'b1; step(1); inject = 1'b0;
        step(5);
        check("f034_idle_tick", 64'(n_starts - base), 64'd0);
        i_latch_data = 44'h800_0000_00FF;
        i_start = 1'b1;
        step(1);
        i_start = 1'b0; inject = 1'b1;
        check("f034_send_cycle", 64'(o_tx_start), 64'd1);
        step(1);
        inject = 1'b0;
        wait_done("f034", 300);
        step(2);
        cmp_frame("f034", base, exp_034);
        check("f034_starts", 64'(n_starts - base), 64'd7);

        // Reset mid-frame aborts without o_done
        base = n_starts;
        pulse_start(44'h8AB_CDEF_0123);
        wait_starts("f035", base + 4, 200);
        step(2);
        i_reset = 1'b0;
        #1;
        check("f035_rst_tx_start", 64'(o_tx_start), 64'd0);
        check("f035_rst_tx_data",  64'(o_tx_data),  64'd0);
        check("f035_rst_busy",     64'(o_busy),     64'd0);
        check("f035_rst_done",     64'(o_done),     64'd0);
        check("f035_rst_eof",      64'(o_eof_seen), 64'd0);
        step(1);
        i_reset = 1'b1;
        d0 = n_dones;
        step(40);
        check("f035_no_done",  64'(n_dones - d0),    64'd0);
        check("f035_no_start", 64'(n_starts - base), 64'd4);
        base = n_starts;
        pulse_start(44'h8AB_CDEF_0123);
        wait_done("f035b", 300);
        step(2);
        cmp_frame("f035b", base, exp_032);

        // Held start gives back-to-back frames
        base = n_starts; d0 = n_dones;
        resp_delay = 3;
        i_latch_data = 44'h000_0000_0003;
        i_start = 1'b1;
        wait_done("f036a", 200);
        step(3);
        d1 = last_done_cyc;
        wait_starts("f036", base + 8, 50);
        check("f036_done_to_hdr", 64'(start_cyc[base + 7] - d1), 64'd2);
        check("f036_idle_gap",    64'(last_idle_run),          64'd1);
        wait_done("f036b", 200);
        i_start = 1'b0;
        step(20);
        check("f036_starts", 64'(n_starts - base), 64'd14);
        check("f036_dones",  64'(n_dones - d0),    64'd2);

        // EOF clear snapshot
        base = n_starts;
        resp_delay = 10;
        pulse_start(44'h000_0000_0003);
        wait_done("f037", 300);
        step(2);
        cmp_frame("f037", base, exp_037);
        check("f037_eof", 64'(o_eof_seen), 64'd0);

        // Randomized frames with data churn and random UART latency
        noise = 1'b1;
        for (int f = 0; f < 25; f++) begin
            base = n_starts;
            resp_delay = int'($urandom_range(1, 12));
            i_latch_data = 44'({$urandom, $urandom});
            i_start = 1'b1;
            step(int'($urandom_range(1, 3)));
            i_start = 1'b0;
            wait_done($sformatf("rand%0d", f), 400);
            step(int'($urandom_range(1, 4)));
            check($sformatf("rand%0d_starts", f), 64'(n_starts - base), 64'd7);
        end
        noise = 1'b0;

        step(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
